// File: rtl/mac_rx_pkg.sv
// Shared types and defaults for the MAC receive read controller.
// Holds the FSM state encoding and the end-of-packet byte-enable decode.
package mac_rx_pkg;

    localparam int MAX_PKT_BYTES_DEF = 1518;
    localparam int TIMEOUT_CYC_DEF   = 255;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_DATA = 3'd2,
        ST_DESC = 3'd3,
        ST_DROP = 3'd4
    } state_e;

    // A zero byte enable on the eop word means the whole word is valid.
    function automatic logic [2:0] ben_decode(input logic [1:0] ben);
        return (ben == 2'b00) ? 3'd4 : {1'b0, ben};
    endfunction

endpackage

// File: rtl/mac_rx_read_ctrl_if.sv
// Downstream side of the receive controller: buffer write port and frame descriptor.
// The master modport is the controller, the slave modport is the buffer/descriptor consumer.
interface mac_rx_read_ctrl_if #(
    parameter int BUF_AW = 12
);

    logic [BUF_AW:0] buf_wfree_i;
    logic [31:0]     buf_wdata_o;
    logic            buf_wen_o;
    logic            buf_wlast_o;
    logic            buf_abort_o;
    logic            desc_valid_o;
    logic            desc_ready_i;
    logic [15:0]     desc_len_o;
    logic            desc_err_o;

    modport master (
        input  buf_wfree_i,
        input  desc_ready_i,
        output buf_wdata_o,
        output buf_wen_o,
        output buf_wlast_o,
        output buf_abort_o,
        output desc_valid_o,
        output desc_len_o,
        output desc_err_o
    );

    modport slave (
        output buf_wfree_i,
        output desc_ready_i,
        input  buf_wdata_o,
        input  buf_wen_o,
        input  buf_wlast_o,
        input  buf_abort_o,
        input  desc_valid_o,
        input  desc_len_o,
        input  desc_err_o
    );

endinterface

// File: rtl/mac_rx_len_cnt.sv
// Frame byte accumulator with 16-bit saturation and the oversize-frame compare.
// over_o looks ahead: it reports whether adding bytes_i would exceed the frame limit.
module mac_rx_len_cnt
    import mac_rx_pkg::*;
#(
    parameter int MAX_PKT_BYTES = MAX_PKT_BYTES_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        first_i,
    input  logic        commit_i,
    input  logic [2:0]  bytes_i,
    output logic [15:0] len_o,
    output logic        over_o
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_BYTES);

    logic [15:0] len_q;
    logic [15:0] len_d;
    logic [16:0] sum_raw;
    logic [15:0] sum_sat;

    assign sum_raw = {1'b0, len_q} + {14'd0, bytes_i};
    assign sum_sat = sum_raw[16] ? 16'hFFFF : sum_raw[15:0];
    assign over_o  = (sum_sat > MAX_LEN);
    assign len_o   = len_q;

    always_comb begin
        len_d = len_q;
        if (first_i) begin
            len_d = {13'd0, bytes_i};
        end else if (commit_i) begin
            len_d = sum_sat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q <= 16'd0;
        end else begin
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/mac_rx_read_ctrl.sv
// Pulls frames out of the MAC receive FIFO into a downstream buffer and emits one
// descriptor per good frame; oversize, truncated or stalled frames are rolled back.
module mac_rx_read_ctrl
    import mac_rx_pkg::*;
#(
    parameter int MAX_PKT_BYTES = MAX_PKT_BYTES_DEF,
    parameter int BUF_AW        = 12,
    parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
    input  logic               mac_clk_i,
    input  logic               mac_rst_i,
    input  logic [31:0]        mac_rxd_i,
    input  logic [1:0]         mac_ben_i,
    input  logic               mac_rxda_i,
    input  logic               mac_rxsop_i,
    input  logic               mac_rxeop_i,
    input  logic               mac_rxdv_i,
    output logic               mac_rxrqrd_o,
    mac_rx_read_ctrl_if.master bus_if,
    output logic [31:0]        stat_pkt_cnt_o,
    output logic [31:0]        stat_drop_cnt_o,
    output logic               idle_o
);

    localparam logic [31:0] WORDS_NEEDED = 32'((MAX_PKT_BYTES + 3) / 4);
    localparam int          TW           = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        timer_run, timeout_hit;

    logic [BUF_AW:0] wfree;
    logic        room_ok;
    logic [2:0]  word_bytes;
    logic [15:0] len_q;
    logic        len_over;

    logic        wr_ev, last_ev, abort_ev, drop_ev, pkt_ev;
    logic        len_first, len_commit;

    logic        desc_valid_d;
    logic [15:0] desc_len_d;

    logic [31:0] wdata_q;
    logic        wen_q, wlast_q, abort_q;
    logic [31:0] pkt_cnt_q, drop_cnt_q;

    assign wfree      = bus_if.buf_wfree_i;
    assign room_ok    = ({{(31 - BUF_AW){1'b0}}, wfree} >= WORDS_NEEDED);
    assign word_bytes = mac_rxeop_i ? ben_decode(mac_ben_i) : 3'd4;

    assign timer_run   = ((state_q == ST_REQ) || (state_q == ST_DATA) || (state_q == ST_DROP))
                         && !mac_rxdv_i;
    assign timer_d     = timer_run ? (timer_q + 1'b1) : '0;
    assign timeout_hit = timer_run && (timer_q == TIMER_LAST);

    mac_rx_len_cnt #(
        .MAX_PKT_BYTES (MAX_PKT_BYTES)
    ) u_len_cnt (
        .clk_i    (mac_clk_i),
        .rst_i    (mac_rst_i),
        .first_i  (len_first),
        .commit_i (len_commit),
        .bytes_i  (word_bytes),
        .len_o    (len_q),
        .over_o   (len_over)
    );

    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // A sop always opens a frame with its first word; the first word alone can never be oversize.
    always_comb begin
        state_d    = state_q;
        wr_ev      = 1'b0;
        last_ev    = 1'b0;
        abort_ev   = 1'b0;
        drop_ev    = 1'b0;
        pkt_ev     = 1'b0;
        len_first  = 1'b0;
        len_commit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mac_rxda_i && !desc_valid_d && room_ok) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mac_rxdv_i && mac_rxsop_i) begin
                    len_first = 1'b1;
                    wr_ev     = 1'b1;
                    last_ev   = mac_rxeop_i;
                    state_d   = mac_rxeop_i ? ST_DESC : ST_DATA;
                end else if (mac_rxdv_i) begin
                    drop_ev = 1'b1;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (mac_rxdv_i && mac_rxsop_i) begin
                    abort_ev  = 1'b1;
                    drop_ev   = 1'b1;
                    len_first = 1'b1;
                    wr_ev     = 1'b1;
                    last_ev   = mac_rxeop_i;
                    state_d   = mac_rxeop_i ? ST_DESC : ST_DATA;
                end else if (mac_rxdv_i && len_over) begin
                    abort_ev = 1'b1;
                    drop_ev  = 1'b1;
                    state_d  = mac_rxeop_i ? ST_IDLE : ST_DROP;
                end else if (mac_rxdv_i) begin
                    len_commit = 1'b1;
                    wr_ev      = 1'b1;
                    last_ev    = mac_rxeop_i;
                    if (mac_rxeop_i) begin
                        state_d = ST_DESC;
                    end
                end else if (timeout_hit) begin
                    abort_ev = 1'b1;
                    drop_ev  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DESC: begin
                if (bus_if.desc_ready_i) begin
                    pkt_ev  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if ((mac_rxdv_i && mac_rxeop_i) || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mac_rxrqrd_o = (state_q == ST_REQ) || (state_q == ST_DATA);
        idle_o       = (state_q == ST_IDLE);
        desc_valid_d = (state_q == ST_DESC);
        desc_len_d   = desc_valid_d ? len_q : 16'd0;
    end

    // On a sop restart abort and the new frame's first write land together: roll back, then write.
    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            wdata_q    <= 32'd0;
            wen_q      <= 1'b0;
            wlast_q    <= 1'b0;
            abort_q    <= 1'b0;
            pkt_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else begin
            wen_q   <= wr_ev;
            wlast_q <= last_ev;
            abort_q <= abort_ev;
            if (wr_ev) begin
                wdata_q <= mac_rxd_i;
            end
            if (pkt_ev) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (drop_ev) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign bus_if.buf_wdata_o  = wdata_q;
    assign bus_if.buf_wen_o    = wen_q;
    assign bus_if.buf_wlast_o  = wlast_q;
    assign bus_if.buf_abort_o  = abort_q;
    assign bus_if.desc_valid_o = desc_valid_d;
    assign bus_if.desc_len_o   = desc_len_d;
    assign bus_if.desc_err_o   = 1'b0;
    assign stat_pkt_cnt_o      = pkt_cnt_q;
    assign stat_drop_cnt_o     = drop_cnt_q;

endmodule

// File: doc/mac_rx_read_ctrl.md
MAC_RX_READ_CTRL -- requirements
Module: mac_rx_read_ctrl

Interface
REQ-001 SHALL have parameter MAX_PKT_BYTES, default 1518: largest accepted frame length in bytes.
REQ-002 SHALL have parameter BUF_AW, default 12: log2 of receive buffer depth in 32-bit words.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: maximum cycles with mac_rxrqrd_o high and no mac_rxdv_i before abandoning the request.
REQ-004 SHALL have port mac_clk_i  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port mac_rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port mac_rxd_i  in  32  receive data word from the MAC.
REQ-007 SHALL have port mac_ben_i  in  2  byte enable, qualified by mac_rxeop_i: 2'b00 = 4 valid bytes; otherwise the value is the valid byte count.
REQ-008 SHALL have port mac_rxda_i  in  1  MAC has frame data available.
REQ-009 SHALL have ports mac_rxsop_i, mac_rxeop_i, mac_rxdv_i  in  1 each  start of packet, end of packet, data valid.
REQ-010 SHALL have port mac_rxrqrd_o  out  1  read request to the MAC.
REQ-011 SHALL have port buf_wfree_i  in  BUF_AW+1  free words in the downstream buffer.
REQ-012 SHALL have ports buf_wdata_o (out, 32), buf_wen_o (out, 1), buf_wlast_o (out, 1) and buf_abort_o (out, 1): buffer write data, write strobe, last word of frame, and roll back uncommitted frame.
REQ-013 SHALL have ports desc_valid_o (out, 1), desc_ready_i (in, 1), desc_len_o (out, 16) and desc_err_o (out, 1): frame descriptor handshake, frame length in bytes, and error flag.
REQ-014 SHALL have ports stat_pkt_cnt_o (out, 32), stat_drop_cnt_o (out, 32) and idle_o (out, 1).

Function
REQ-015 SHALL implement FSM states IDLE, REQ, DATA, DESC and DROP.
REQ-016 IDLE->REQ SHALL occur when mac_rxda_i=1, desc_valid_o=0, and buf_wfree_i >= ceil(MAX_PKT_BYTES/4); mac_rxrqrd_o SHALL be 1 in REQ and DATA only.
REQ-017 In REQ, mac_rxdv_i&mac_rxsop_i SHALL move to DATA and accept the word; mac_rxdv_i without sop SHALL be discarded and counted as a drop; TIMEOUT_CYC cycles without dv SHALL return to IDLE.
REQ-018 Each accepted word (dv=1) SHALL appear on buf_wdata_o with buf_wen_o=1 exactly one cycle later (registered, latency 1); buf_wlast_o SHALL accompany the eop word.
REQ-019 The byte counter SHALL add 4 per non-eop word and decode(mac_ben_i) on the eop word; the width SHALL be 16 bits, saturating at 16'hFFFF.
REQ-020 On eop in DATA, the FSM SHALL go to DESC with desc_len_o = byte count and desc_err_o=0; desc_valid_o SHALL hold until desc_ready_i=1, then return to IDLE.
REQ-021 If the byte count would exceed MAX_PKT_BYTES, the FSM SHALL enter DROP, stop buf_wen_o, pulse buf_abort_o for 1 cycle, and consume words until eop, then return to IDLE; stat_drop_cnt_o SHALL increment by 1.
REQ-022 mac_rxsop_i seen in DATA before eop SHALL abort the current frame (buf_abort_o pulse, drop count +1) and start the new frame in the same cycle.
REQ-023 A dv gap in DATA longer than TIMEOUT_CYC SHALL abort as in REQ-021 and go to IDLE.
REQ-024 stat_pkt_cnt_o SHALL increment on each descriptor handshake; both counters SHALL wrap modulo 2^32.
REQ-025 idle_o SHALL be 1 exactly when the state is IDLE.
REQ-026 Simultaneous sop and eop with dv SHALL form a 1-word frame of decode(ben) bytes.

Reset
REQ-027 mac_rst_i=1 SHALL force state IDLE and drive all outputs and counters to 0 on the next edge, including mid-frame; no buf_abort_o pulse SHALL be generated by reset.
REQ-028 The first request after reset release SHALL be raised no earlier than the cycle after mac_rst_i falls.

Structure
REQ-029 A shared package mac_rx_pkg SHALL hold the FSM state enum, the ben decode function, and the MAX_PKT_BYTES/TIMEOUT_CYC defaults.
REQ-030 A sub-module mac_rx_len_cnt SHALL hold the byte accumulator and the overflow compare.

Verification
REQ-031 Verify a 64-byte frame (16 words, eop ben=00): 16 buf_wen_o pulses, wlast on the 16th, desc_len_o=64, stat_pkt_cnt_o=1.
REQ-032 Verify a 61-byte frame (eop ben=01): desc_len_o=61.
REQ-033 Verify a 1600-byte frame with MAX_PKT_BYTES=1518: buf_abort_o pulses once, no descriptor is issued, stat_drop_cnt_o=1, and the FSM returns to IDLE after eop.
REQ-034 Verify buf_wfree_i=100 with mac_rxda_i=1: mac_rxrqrd_o stays 0; raising buf_wfree_i to 380 raises it the next cycle.
REQ-035 Verify mac_rst_i=1 asserted mid-frame at word 5: all outputs are 0 the next cycle, and no descriptor or abort is produced.
REQ-036 Verify desc_ready_i held 0 for 20 cycles: desc_valid_o and desc_len_o stay stable, and no new request is raised until the handshake completes.
